// File: rtl/freq_meter_display.sv
// Gated edge counter with double-dabble BCD conversion driving a multiplexed
// N-digit seven-segment display with leading-zero blanking and overflow dashes.
module freq_meter_display #(
  parameter int GATE_CYCLES    = 100000000,
  parameter int CNT_W          = 32,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal,
  output logic [6:0]            Seg,
  output logic [NUM_DIGITS-1:0] Dig,
  output logic                  overflow,
  output logic                  valid
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SHIFT_W = $clog2(CNT_W + 1);
  localparam int BCD_W   = 4 * (NUM_DIGITS + 1);
  localparam logic [63:0] MAX_DISP = 64'(10 ** NUM_DIGITS) - 64'd1;
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h00;
    endcase
  endfunction

  // Input synchroniser and rising-edge detect
  logic sync_1, sync_2, sync_prev, edge_pulse;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= signal;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign edge_pulse = sync_2 & ~sync_prev;

  // Gate window and saturating edge counter
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt, cnt_next, result;
  logic              gate_end;

  assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  assign cnt_next = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      result   <= '0;
    end else if (gate_end) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      result   <= cnt_next;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      edge_cnt <= cnt_next;
    end
  end

  // Conversion FSM
  conv_state_t        state, state_next;
  logic [SHIFT_W-1:0] shift_cnt;
  logic [CNT_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [3:0]         disp [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gate_end) state_next = SHIFT;
      SHIFT:   if (shift_cnt == SHIFT_W'(CNT_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: the display digit array is a handful of flops, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt <= '0;
      bin_sr    <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gate_end) begin
            bin_sr    <= cnt_next;
            bcd       <= '0;
            shift_cnt <= '0;
          end
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          shift_cnt     <= shift_cnt + SHIFT_W'(1);
        end
        DONE: begin
          overflow <= (64'(result) > MAX_DISP);
          valid    <= 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= bcd[4*i +: 4];
        end
        default: ;
      endcase
    end
  end

  // Digit scan; Dig and Seg are both registered from the same idx
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic              upper_zero;
  logic [6:0]        seg_lit;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (disp[i] != 4'd0)) upper_zero = 1'b0;
    end
    seg_lit = 7'h00;
    if (valid) begin
      if (overflow)                       seg_lit = 7'h40;
      else if ((idx == '0) || !upper_zero) seg_lit = seg_pattern(disp[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      Dig      <= '1;
      Seg      <= SEG_OFF;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      Dig <= ~(NUM_DIGITS'(1) << idx);
      Seg <= seg_lit ^ {7{SEG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_freq_meter_display.sv
// Bench for freq_meter_display: a 4-digit and a 1-digit instance share one stimulus
// and are compared every cycle against a decimal-arithmetic model of the meter.
module tb_freq_meter_display;

  localparam int G    = 100;
  localparam int CW   = 16;
  localparam int SD   = 4;
  localparam int MAXC = 65535;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] dig_a;
  logic [0:0] dig_b;
  logic       ovf_a, ovf_b, vld_a, vld_b;

  always #5 clk = ~clk;

  freq_meter_display #(.GATE_CYCLES(G), .CNT_W(CW), .NUM_DIGITS(4), .SCAN_DIV(SD),
                       .SEG_ACTIVE_LOW(1'b1)) dut_4 (
    .clk(clk), .rst_n(rst_n), .signal(sig), .Seg(seg_a), .Dig(dig_a),
    .overflow(ovf_a), .valid(vld_a));

  freq_meter_display #(.GATE_CYCLES(G), .CNT_W(CW), .NUM_DIGITS(1), .SCAN_DIV(SD),
                       .SEG_ACTIVE_LOW(1'b1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .signal(sig), .Seg(seg_b), .Dig(dig_b),
    .overflow(ovf_b), .valid(vld_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: n = clock edges since reset release
  typedef struct { int pub_at; int value; } pub_t;
  pub_t pend[$];
  int   n = 0;
  int   acc = 0;
  bit   hist [4];
  bit   pub_valid = 0, prev_valid = 0;
  int   pub_value = 0, prev_value = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= 10;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_step();
    bit pulse;
    if (!rst_n) begin
      n = 0; acc = 0; pend.delete();
      for (int i = 0; i < 4; i++) hist[i] = 1'b0;
      pub_valid = 0; pub_value = 0; prev_valid = 0; prev_value = 0;
    end else begin
      prev_valid = pub_valid;
      prev_value = pub_value;
      n++;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sig;
      pulse = hist[2] && !hist[3];
      if (n % G == 0) begin
        pend.push_back('{n + CW + 1, sat(acc + int'(pulse))});
        acc = 0;
      end else begin
        acc = sat(acc + int'(pulse));
      end
      if (pend.size() > 0 && pend[0].pub_at == n) begin
        pub_valid = 1;
        pub_value = pend[0].value;
        void'(pend.pop_front());
      end
    end
  endtask

  function automatic logic [6:0] exp_seg(input int nd);
    int idx;
    if (n == 0 || !prev_valid) return 7'h7F;
    idx = ((n - 1) / SD) % nd;
    if (prev_value > pow10(nd) - 1) return ~7'h40;
    if (idx > 0 && prev_value < pow10(idx)) return 7'h7F;
    return ~pat[(prev_value / pow10(idx)) % 10];
  endfunction

  function automatic logic [31:0] exp_dig(input int nd);
    int mask = (1 << nd) - 1;
    if (n == 0) return 32'(mask);
    return 32'(~(1 << (((n - 1) / SD) % nd)) & mask);
  endfunction

  always @(posedge clk) begin
    model_step();
    #2;
    check("seg_nd4", 32'(seg_a), 32'(exp_seg(4)));
    check("dig_nd4", 32'(dig_a), exp_dig(4));
    check("ovf_nd4", 32'(ovf_a), 32'(pub_valid && pub_value > 9999));
    check("vld_nd4", 32'(vld_a), 32'(pub_valid));
    check("seg_nd1", 32'(seg_b), 32'(exp_seg(1)));
    check("dig_nd1", 32'(dig_b), exp_dig(1));
    check("ovf_nd1", 32'(ovf_b), 32'(pub_valid && pub_value > 9));
    check("vld_nd1", 32'(vld_b), 32'(pub_valid));
  end

  // Signal generator: 0 random, 1 period-4 aligned so an edge lands on gate end,
  // 2 held low, 3 random toggling with density, 4 toggle every cycle
  int mode = 0;
  int density = 2;

  always @(negedge clk) begin
    case (mode)
      0:       sig = 1'($urandom_range(0, 1));
      1:       sig = ((n + 1) % 4 >= 2);
      2:       sig = 1'b0;
      3:       if ($urandom_range(0, density) == 0) sig = ~sig;
      default: sig = ~sig;
    endcase
  end

  task automatic wait_n(input int target);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (n >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_n: edge count %0d never reached %0d", n, target);
  endtask

  logic [3:0] dig_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    // Reset with a toggling input
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_a), 32'h7F);
    check("rst_dig", 32'(dig_a), 32'hF);
    check("rst_vld", 32'(vld_a), 32'h0);
    mode = 1;
    @(negedge clk);
    rst_n = 1'b1;

    // Blank display while scanning before the first result
    wait_n(50);
    check("pre_seg", 32'(seg_a), 32'h7F);
    check("pre_vld", 32'(vld_a), 32'h0);

    // 25 edges per gate, one of them exactly on the gate-end cycle
    wait_n(120);
    check("model_gate1", 32'(pub_value), 32'd25);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #3;
      case (dig_a)
        4'hE:    check("lit25_d0", 32'(seg_a), 32'h12);
        4'hD:    check("lit25_d1", 32'(seg_a), 32'h24);
        default: check("lit25_hi", 32'(seg_a), 32'h7F);
      endcase
      check("lit25_ovf1", 32'(ovf_b), 32'h1);
      check("lit25_seg1", 32'(seg_b), 32'h3F);
    end

    // Input held low: a full gate of zero edges
    mode = 2;
    wait_n(425);
    check("model_zero", 32'(pub_value), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #3;
      if (dig_a == 4'hE) check("lit0_d0", 32'(seg_a), 32'h40);
      else               check("lit0_hi", 32'(seg_a), 32'h7F);
      check("lit0_ovf1", 32'(ovf_b), 32'h0);
      check("lit0_seg1", 32'(seg_b), 32'h40);
    end

    // Reset eight cycles into a conversion: nothing may be published
    mode = 3;
    density = 1;
    wait_n(508);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #3;
      check("abort_dig", 32'(dig_a), 32'(dig_seq[(c / 4) % 4]));
      check("abort_vld", 32'(vld_a), 32'h0);
      check("abort_seg", 32'(seg_a), 32'h7F);
    end

    // Randomised phases of varying edge density
    for (int ph = 0; ph < 8; ph++) begin
      mode = (ph == 3) ? 4 : 3;
      density = $urandom_range(0, 4);
      repeat (150) @(negedge clk);
    end
    repeat (130) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
